hmc960_spi_target: RTL and testbench

// - Behavioural-synthesizable HMC960 serial-port responder (SEN/SCLK/SDI/SDO) with a 32x24 register file.
// - Acts as the chip-side end of the link for loopback test on the DE0-Nano and for bench use against the master.
// - Runs fully synchronous to the 50 MHz system clk; the serial pins are oversampled.

---
 rtl/hmc960_spi_target_pkg.sv | 48 ++++
 rtl/hmc960_spi_target_sync_edge.sv | 33 +++
 rtl/hmc960_spi_target.sv | 156 +++++++++++++++
 tb/tb_hmc960_spi_target.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/hmc960_spi_target_pkg.sv
// Shared definitions for the HMC960 serial-port target: field widths,
// FSM encoding, frame layout and a frame packing helper.
package hmc960_spi_target_pkg;

   localparam int DATA_W   = 24;
   localparam int ADDR_W   = 5;
   localparam int CHIP_W   = 3;
   localparam int FRAME_W  = 32;
   localparam int NUM_REGS = 32;
   localparam int CNT_W    = 6;

   // bit counter stops here so over-long frames cannot wrap back to 32
   localparam logic [CNT_W-1:0]  BIT_SAT  = 6'd33;
   localparam logic [CNT_W-1:0]  CNT_FULL = 6'd32;

   // writing this register also moves the readback pointer
   localparam logic [ADDR_W-1:0] READ_PTR_REG  = '0;
   localparam logic [CHIP_W-1:0] CHIP_ADDR_DEF = 3'b110;

   // serial pins are synchronized as one small lane vector
   localparam int NUM_PINS = 3;
   localparam int PIN_SEN  = 2;
   localparam int PIN_SCLK = 1;
   localparam int PIN_SDI  = 0;

   typedef enum logic [1:0] {
      ST_ARM    = 2'd0,
      ST_IDLE   = 2'd1,
      ST_SHIFT  = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   // on-wire frame, MSB first
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] addr;
      logic [CHIP_W-1:0] chip;
   } frame_t;

   function automatic logic [FRAME_W-1:0] frame_pack(
      input logic [DATA_W-1:0] data,
      input logic [ADDR_W-1:0] addr,
      input logic [CHIP_W-1:0] chip
   );
      return {data, addr, chip};
   endfunction

endpackage

// File: rtl/hmc960_spi_target_sync_edge.sv
// Multi-flop synchronizer for one serial pin with rise/fall pulses taken
// from the synchronized copy. Everything resets low, so a pin already low
// at reset release never produces a spurious falling edge.
module hmc960_spi_target_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // synchronizer chain plus one delayed copy for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign q    = sync_q[STAGES-1];
   assign rise =  q & ~prev_q;
   assign fall = ~q &  prev_q;

endmodule

// File: rtl/hmc960_spi_target.sv
// HMC960 serial-port responder: oversamples SEN/SCLK/SDI on clk, shifts
// 32-bit frames in and readback data out, and commits writes into a
// 32x24 register file. Writing register 0 also selects which register the
// next frame returns on SDO.
module hmc960_spi_target
   import hmc960_spi_target_pkg::*;
#(
   parameter logic [CHIP_W-1:0] CHIP_ADDR   = CHIP_ADDR_DEF,
   parameter int                SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sen,
   input  logic              sclk,
   input  logic              sdi,
   output logic              sdo,
   output logic              sdo_oe,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              frame_err,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy
);

   logic [NUM_PINS-1:0] pins, pin_q, pin_rise, pin_fall;
   logic                sen_q, sen_rise, sen_fall, sclk_rise, sclk_fall, sdi_q;
   logic                unused_pins;

   state_t                         state, state_nx;
   logic [CNT_W-1:0]               bit_cnt;
   logic [FRAME_W-1:0]             rx_sr, tx_sr, tx_load;
   frame_t                         rx_f;
   logic [ADDR_W-1:0]              rd_ptr;
   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   logic                           frame_ok, chip_ok, wr_en;

   assign pins = {sen, sclk, sdi};

   for (genvar i = 0; i < NUM_PINS; i++) begin : g_sync
      hmc960_spi_target_sync_edge #(
         .STAGES (SYNC_STAGES)
      ) u_sync (
         .clk   (clk),
         .reset (reset),
         .d     (pins[i]),
         .q     (pin_q[i]),
         .rise  (pin_rise[i]),
         .fall  (pin_fall[i])
      );
   end

   assign sen_q     = pin_q[PIN_SEN];
   assign sen_rise  = pin_rise[PIN_SEN];
   assign sen_fall  = pin_fall[PIN_SEN];
   assign sclk_rise = pin_rise[PIN_SCLK];
   assign sclk_fall = pin_fall[PIN_SCLK];
   assign sdi_q     = pin_q[PIN_SDI];
   assign unused_pins = ^{pin_q[PIN_SCLK], pin_rise[PIN_SDI], pin_fall[PIN_SDI]};

   // frame decode and commit qualifiers
   assign rx_f     = frame_t'(rx_sr);
   assign frame_ok = (bit_cnt == CNT_FULL);
   assign chip_ok  = (rx_f.chip == CHIP_ADDR);
   assign wr_en    = (state == ST_COMMIT) && frame_ok && chip_ok;
   assign tx_load  = frame_pack(regs[rd_ptr], rd_ptr, CHIP_ADDR);

   assign sdo_oe = (state == ST_SHIFT);
   assign busy   = (state == ST_SHIFT);

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_ARM;
      else       state <= state_nx;
   end

   // next state: ARM waits out any frame that was in flight at reset release
   always_comb begin
      state_nx = state;
      case (state)
         ST_ARM:    if (sen_q)    state_nx = ST_IDLE;
         ST_IDLE:   if (sen_fall) state_nx = ST_SHIFT;
         ST_SHIFT:  if (sen_rise) state_nx = ST_COMMIT;
         ST_COMMIT:               state_nx = ST_IDLE;
         default:                 state_nx = ST_ARM;
      endcase
   end

   // shift datapath, readback pointer and commit strobes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt   <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         sdo       <= 1'b0;
         rd_ptr    <= '0;
         wr_valid  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         frame_err <= 1'b0;
      end else begin
         wr_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               sdo <= 1'b0;
               if (sen_fall) begin
                  bit_cnt <= '0;
                  tx_sr   <= tx_load;
                  sdo     <= tx_load[FRAME_W-1];
               end
            end
            ST_SHIFT: begin
               // an SCLK edge landing with SEN release is dropped
               if (!sen_rise) begin
                  if (sclk_rise) begin
                     rx_sr <= {rx_sr[FRAME_W-2:0], sdi_q};
                     if (bit_cnt != BIT_SAT) bit_cnt <= bit_cnt + 1'b1;
                  end
                  if (sclk_fall) begin
                     // zeros shift in, so SDO reads 0 once all 32 bits are out
                     tx_sr <= tx_sr << 1;
                     sdo   <= tx_sr[FRAME_W-2];
                  end
               end
            end
            ST_COMMIT: begin
               sdo <= 1'b0;
               if (!frame_ok) begin
                  frame_err <= 1'b1;
               end else if (chip_ok) begin
                  wr_valid <= 1'b1;
                  wr_addr  <= rx_f.addr;
                  wr_data  <= rx_f.data;
                  if (rx_f.addr == READ_PTR_REG) rd_ptr <= rx_f.data[ADDR_W-1:0];
               end
            end
            default: sdo <= 1'b0;
         endcase
      end
   end

   // register file; commit writes only on a complete, addressed frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      regs <= '0;
      else if (wr_en) regs[rx_f.addr] <= rx_f.data;
   end

   // fabric read port, one clock latency, no write bypass
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rd_data <= '0;
      else       rd_data <= regs[rd_addr];
   end

endmodule

// File: tb/tb_hmc960_spi_target.sv
// Directed bench for hmc960_spi_target: drives SPI frames at clk/10 and
// checks writes, readback, chip filtering, bad lengths and mid-frame reset.
module tb_hmc960_spi_target;
   import hmc960_spi_target_pkg::*;

   logic        clk = 1'b0, reset = 1'b1, sen = 1'b1, sclk = 1'b0, sdi = 1'b0;
   logic [4:0]  rd_addr = '0;
   logic        sdo, sdo_oe, wr_valid, frame_err, busy;
   logic [4:0]  wr_addr;
   logic [23:0] wr_data, rd_data;

   int total = 0, bad = 0, wr_cnt = 0, err_cnt = 0;
   logic [4:0]  last_addr = '0;
   logic [23:0] last_data = '0;

   hmc960_spi_target dut (
      .clk(clk), .reset(reset), .sen(sen), .sclk(sclk), .sdi(sdi),
      .sdo(sdo), .sdo_oe(sdo_oe), .wr_valid(wr_valid), .wr_addr(wr_addr),
      .wr_data(wr_data), .frame_err(frame_err), .rd_addr(rd_addr),
      .rd_data(rd_data), .busy(busy)
   );

   always #10 clk = ~clk;

   // pulse counters; a stuck-high strobe shows up as extra counts
   always @(negedge clk) begin
      if (wr_valid) begin
         wr_cnt    = wr_cnt + 1;
         last_addr = wr_addr;
         last_data = wr_data;
      end
      if (frame_err) err_cnt = err_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // one SCLK period; SDO sampled just before the rising edge
   task automatic send_bit(input logic b, output logic so, output logic oe);
      sdi = b;
      wait_clk(5);
      so   = sdo;
      oe   = sdo_oe;
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] f, input int nbits,
                             output logic [31:0] miso, output logic oe_all);
      logic so, oe;
      miso   = '0;
      oe_all = 1'b1;
      sen    = 1'b0;
      wait_clk(5);
      for (int i = 0; i < nbits; i++) begin
         send_bit((i < 32) ? f[31-i] : 1'b0, so, oe);
         if (i < 32) miso = {miso[30:0], so};
         oe_all = oe_all & oe;
      end
      wait_clk(5);
      sen = 1'b1;
   endtask

   task automatic read_reg(input logic [4:0] a, output logic [23:0] d);
      rd_addr = a;
      wait_clk(1);
      d = rd_data;
   endtask

   initial begin
      logic [31:0] miso, f;
      logic        oe_all, so, oe;
      logic [23:0] d;
      int          w0, e0;

      // reset state
      wait_clk(3);
      chk("rst_sdo", {31'd0, sdo}, 32'd0);
      chk("rst_oe", {31'd0, sdo_oe}, 32'd0);
      chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
      chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rd_data", {8'd0, rd_data}, 32'd0);
      chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
      reset = 1'b0;
      wait_clk(10);

      // plain write; readback shows reg0=0, ptr 0, chip 110
      w0 = wr_cnt; e0 = err_cnt;
      send_frame(32'hABCDEF_3E, 32, miso, oe_all);
      wait_clk(10);
      chk("wr1_count", wr_cnt - w0, 1);
      chk("wr1_err", err_cnt - e0, 0);
      chk("wr1_addr", {27'd0, last_addr}, 32'd7);
      chk("wr1_data", {8'd0, last_data}, 32'h00ABCDEF);
      chk("wr1_miso", miso, 32'h00000006);
      chk("wr1_oe", {31'd0, oe_all}, 32'd1);
      chk("post_oe", {31'd0, sdo_oe}, 32'd0);
      chk("post_busy", {31'd0, busy}, 32'd0);
      read_reg(5'd7, d);
      chk("rd7", {8'd0, d}, 32'h00ABCDEF);

      // reg0 <- 7 selects reg 7 for readback
      w0 = wr_cnt;
      send_frame(32'h000007_06, 32, miso, oe_all);
      wait_clk(10);
      chk("ptr_count", wr_cnt - w0, 1);
      chk("ptr_addr", {27'd0, last_addr}, 32'd0);
      chk("ptr_miso", miso, 32'h00000006);

      // next frame returns {reg7, 00111, 110}; also writes reg3
      w0 = wr_cnt;
      send_frame(32'h111111_1E, 32, miso, oe_all);
      wait_clk(10);
      chk("rb_miso", miso, 32'hABCDEF3E);
      chk("rb_count", wr_cnt - w0, 1);
      read_reg(5'd3, d);
      chk("rd3", {8'd0, d}, 32'h00111111);

      // chip mismatch: silent ignore
      w0 = wr_cnt; e0 = err_cnt;
      send_frame(32'h123456_3D, 32, miso, oe_all);
      wait_clk(10);
      chk("chip_wr", wr_cnt - w0, 0);
      chk("chip_err", err_cnt - e0, 0);
      read_reg(5'd7, d);
      chk("chip_rd7", {8'd0, d}, 32'h00ABCDEF);

      // short then long frame: one error each, no write
      w0 = wr_cnt; e0 = err_cnt;
      send_frame(32'h999999_3E, 31, miso, oe_all);
      wait_clk(10);
      chk("short_err", err_cnt - e0, 1);
      send_frame(32'h999999_3E, 33, miso, oe_all);
      wait_clk(10);
      chk("long_err", err_cnt - e0, 2);
      chk("len_wr", wr_cnt - w0, 0);
      read_reg(5'd7, d);
      chk("len_rd7", {8'd0, d}, 32'h00ABCDEF);

      // reset after 16 bits, release with SEN low, finish the frame
      f  = 32'h55AA55_4E;
      w0 = wr_cnt; e0 = err_cnt;
      sen = 1'b0;
      wait_clk(5);
      for (int i = 0; i < 16; i++) send_bit(f[31-i], so, oe);
      reset = 1'b1;
      wait_clk(3);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      wait_clk(3);
      for (int i = 16; i < 32; i++) send_bit(f[31-i], so, oe);
      wait_clk(5);
      sen = 1'b1;
      wait_clk(10);
      chk("mid_wr", wr_cnt - w0, 0);
      chk("mid_err", err_cnt - e0, 0);
      read_reg(5'd9, d);
      chk("mid_rd9", {8'd0, d}, 32'd0);
      send_frame(f, 32, miso, oe_all);
      wait_clk(10);
      chk("after_wr", wr_cnt - w0, 1);
      read_reg(5'd9, d);
      chk("after_rd9", {8'd0, d}, 32'h0055AA55);

      // back-to-back frames with 4 clk SEN-high gaps, all 32 registers
      w0 = wr_cnt;
      for (int a = 0; a < 32; a++) begin
         send_frame({24'((a + 1) * 24'h010101), 5'(a), 3'b110}, 32, miso, oe_all);
         // reg0 <- 010101 set ptr=1; reg1 <- 020202 landed one frame earlier
         if (a == 2) chk("b2b_miso", miso, 32'h0202020E);
         wait_clk(4);
      end
      wait_clk(10);
      chk("b2b_count", wr_cnt - w0, 32);
      for (int a = 0; a < 32; a++) begin
         read_reg(5'(a), d);
         chk($sformatf("b2b_rd%0d", a), {8'd0, d}, 32'((a + 1) * 32'h010101));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
